// File: rtl/act_pkg.sv
// Shared types for the activation scheduler: lane/row types, select code and FSM states.
package act_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int SA_LENGTH  = 8;

  typedef logic [1:0] act_sel_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} act_state_t;

  typedef logic signed [DATA_WIDTH-1:0] lane_t;
  typedef lane_t [SA_LENGTH-1:0]        row_t;
endpackage

// File: rtl/act_scheduler_if.sv
// Config, input-row, activation-unit and output-row signals of act_scheduler.
interface act_scheduler_if #(
  parameter int ROW_W = 9
);
  import act_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  act_sel_t         cfg_sel;
  logic [ROW_W-1:0] cfg_rows;
  logic             in_valid;
  logic             in_ready;
  row_t             in_data;
  row_t             act_in;
  act_sel_t         act_sel;
  row_t             act_out;
  logic             out_valid;
  logic             out_ready;
  row_t             out_data;
  logic             busy;
  logic             done;

  // Controller / environment side.
  modport master (
    output cfg_valid, cfg_sel, cfg_rows, in_valid, in_data, act_out, out_ready,
    input  cfg_ready, in_ready, act_in, act_sel, out_valid, out_data, busy, done
  );

  // Scheduler side.
  modport slave (
    input  cfg_valid, cfg_sel, cfg_rows, in_valid, in_data, act_out, out_ready,
    output cfg_ready, in_ready, act_in, act_sel, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/act_row_fifo.sv
// Synchronous row FIFO with registered read side (no push-to-pop bypass).
module act_row_fifo #(
  parameter int  DEPTH = 3,
  parameter type row_t = logic [7:0],
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  row_t             wdata,
  output row_t             rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  row_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/act_scheduler.sv
// Per-layer sequencer feeding rows through a fixed-latency activation unit into a credit-guarded FIFO.
// Optional ACT_SCHEDULER_PERF_EN adds stall_cycles / row_cycles performance counters.
module act_scheduler
  import act_pkg::*;
#(
  parameter int ACT_LATENCY = 1,
  parameter int MAX_ROWS    = 256
) (
  input  logic           clk,
  input  logic           rst,
  act_scheduler_if.slave bus
`ifdef ACT_SCHEDULER_PERF_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    row_cycles
`endif
);
  localparam int ROW_W     = $clog2(MAX_ROWS + 1);
  localparam int OUT_DEPTH = ACT_LATENCY + 2;
  localparam int CRED_W    = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0]       ST_IDLE  = IDLE;
  localparam logic [1:0]       ST_RUN   = RUN;
  localparam logic [1:0]       ST_DRAIN = DRAIN;
  localparam logic [1:0]       ST_DONE  = DONE;
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [1:0]             state;
  act_sel_t               sel_r;
  logic [ROW_W-1:0]       rows_r;
  logic [ROW_W-1:0]       issued;
  logic [ROW_W-1:0]       retired;
  logic [CRED_W-1:0]      credits;
  logic [ACT_LATENCY-1:0] vld_pipe;
  logic [CRED_W-1:0]      fifo_count;
  logic                   cfg_acc;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  row_t                   head;

  assign cfg_acc      = bus.cfg_valid && (state == ST_IDLE);
  assign bus.in_ready = (state == ST_RUN) && (issued < rows_r) && (credits != '0);
  assign issue        = bus.in_ready && bus.in_valid;
  assign push         = vld_pipe[ACT_LATENCY-1];
  assign pop          = bus.out_valid && bus.out_ready;

  assign bus.cfg_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.act_sel   = sel_r;

  // Stage boundary: issue -> activation unit input (combinational, zero when idle)
  assign bus.act_in = issue ? bus.in_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_r   <= '0;
      rows_r  <= '0;
      issued  <= '0;
      retired <= '0;
    end else begin
      if (cfg_acc) begin
        sel_r   <= bus.cfg_sel;
        rows_r  <= bus.cfg_rows;
        issued  <= '0;
        retired <= '0;
      end else begin
        if (issue) issued  <= issued + ROW_ONE;
        if (pop)   retired <= retired + ROW_ONE;
      end
      case (state)
        ST_IDLE:  if (bus.cfg_valid) state <= (bus.cfg_rows == '0) ? ST_DONE : ST_RUN;
        ST_RUN:   if (issue && (issued + ROW_ONE == rows_r)) state <= ST_DRAIN;
        ST_DRAIN: if (pop && (retired + ROW_ONE == rows_r)) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage boundary: activation unit latency, tracked by the valid pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      credits  <= CRED_W'(OUT_DEPTH);
    end else begin
      vld_pipe <= (vld_pipe << 1) | ACT_LATENCY'(issue);
      case ({issue, pop})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Stage boundary: activation result -> output FIFO
  act_row_fifo #(
    .DEPTH (OUT_DEPTH),
    .row_t (row_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.act_out),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head;

  // Credits cover every FIFO slot, so a push can never meet a full FIFO.
  no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full));
  credit_sum_a:  assert property (@(posedge clk) disable iff (rst)
                   ({1'b0, credits} + {1'b0, fifo_count}) <= (CRED_W + 1)'(OUT_DEPTH));

`ifdef ACT_SCHEDULER_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || cfg_acc) begin
      stall_cycles <= '0;
      row_cycles   <= '0;
    end else begin
      if ((state == ST_RUN) && bus.in_valid && (credits == '0)) stall_cycles <= sat_inc(stall_cycles);
      if (state != ST_IDLE) row_cycles <= sat_inc(row_cycles);
    end
  end
`endif
endmodule

// File: tb/tb_act_scheduler.sv
// Self-checking bench for act_scheduler: layer vector table, scoreboard and hand-written corner sequences.
module tb_act_scheduler;
  import act_pkg::*;

  localparam int ACT_LATENCY = 1;
  localparam int MAX_ROWS    = 256;
  localparam int ROW_W       = $clog2(MAX_ROWS + 1);
  localparam int OUT_DEPTH   = ACT_LATENCY + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  act_scheduler_if #(.ROW_W(ROW_W)) bus ();

`ifdef ACT_SCHEDULER_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] row_cycles;
`endif

  act_scheduler #(
    .ACT_LATENCY (ACT_LATENCY),
    .MAX_ROWS    (MAX_ROWS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ACT_SCHEDULER_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .row_cycles   (row_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench model of the external activation unit: 0 pass, 1 ReLU, 2 halve, 3 invert.
  function automatic row_t act_fn(input row_t r, input act_sel_t s);
    row_t  o;
    lane_t x;
    for (int i = 0; i < SA_LENGTH; i++) begin
      x = r[i];
      case (s)
        2'd0:    o[i] = x;
        2'd1:    o[i] = (x < 0) ? lane_t'(0) : x;
        2'd2:    o[i] = x >>> 1;
        default: o[i] = ~x;
      endcase
    end
    return o;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < SA_LENGTH; i++) r[i] = lane_t'($urandom_range(4095));
    return r;
  endfunction

  row_t act_pipe [ACT_LATENCY];
  always @(posedge clk) begin
    act_pipe[0] <= act_fn(bus.act_in, bus.act_sel);
    for (int i = 1; i < ACT_LATENCY; i++) act_pipe[i] <= act_pipe[i-1];
  end
  assign bus.act_out = act_pipe[ACT_LATENCY-1];

  // Scoreboard: expected rows queued at issue, compared at pop.
  row_t     exp_q [$];
  int       iss_cnt  = 0;
  int       out_cnt  = 0;
  int       done_cnt = 0;
  act_sel_t cur_sel  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(act_fn(bus.in_data, cur_sel));
        iss_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
        else check("sb_has_entry", 128'(exp_q.size()), 128'd1);
      end
      if (bus.done) done_cnt++;
    end
  end

  typedef struct {
    act_sel_t sel;
    int       rows;
    int       vld_pct;
    int       rdy_pct;
    int       hold;
    int       exp_cyc;
    int       exp_hold_iss;
    int       exp_stall;
  } vec_t;

  vec_t vecs [6];

  task automatic check_reset_state(input string tag);
    check({tag, "_cfg_ready"}, bus.cfg_ready, 1);
    check({tag, "_in_ready"},  bus.in_ready,  0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data,  0);
    check({tag, "_act_in"},    bus.act_in,    0);
    check({tag, "_act_sel"},   bus.act_sel,   0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
`ifdef ACT_SCHEDULER_PERF_EN
    check({tag, "_stall"},     stall_cycles,  0);
    check({tag, "_rowcyc"},    row_cycles,    0);
`endif
  endtask

  task automatic run_layer(input vec_t v, output int n_out, output int n_done,
                           output int n_cyc, output int n_hold);
    int o0, d0, i0, budget;
    budget  = 20 * v.rows + 50;
    cur_sel = v.sel;
    o0 = out_cnt; d0 = done_cnt; i0 = iss_cnt;
    n_hold = -1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = v.sel;
    bus.cfg_rows  = ROW_W'(v.rows);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    n_cyc = 0;
    while (done_cnt == d0 && n_cyc < budget) begin
      bus.in_valid  = ($urandom_range(99) < v.vld_pct);
      bus.in_data   = rand_row();
      bus.out_ready = (n_cyc >= v.hold) && ($urandom_range(99) < v.rdy_pct);
      @(negedge clk); #1;
      n_cyc++;
      if (n_cyc == v.hold) n_hold = iss_cnt - i0;
      if (done_cnt == d0) begin
        @(posedge clk); #1;
      end
    end
    if (done_cnt == d0) $display("FAIL layer_timeout: got no done after %0d cycles, required done", n_cyc);
    n_out  = out_cnt - o0;
    n_done = done_cnt - d0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1);
  end

  initial begin
    int   n_out, n_done, n_cyc, n_hold, d0;
    int   r1 [SA_LENGTH] = '{0, 400, 517, -512, -1, -2048, 2047, 52};
    row_t row1;
    vec_t v2;

    vecs[0] = '{2'd2, 16,  100, 100, 0,  16 + ACT_LATENCY + 2, -1,        -1};
    vecs[1] = '{2'd0, 0,   100, 100, 0,  1,                    -1,        -1};
    vecs[2] = '{2'd3, 8,   100, 100, 10, 0,                    OUT_DEPTH, -1};
    vecs[3] = '{2'd1, 20,  60,  50,  0,  0,                    -1,        -1};
    vecs[4] = '{2'd2, 256, 90,  80,  0,  0,                    -1,        -1};
    vecs[5] = '{2'd1, 8,   100, 100, 12, 0,                    OUT_DEPTH, 10};

    bus.cfg_valid = 1'b0; bus.cfg_sel = '0; bus.cfg_rows = '0;
    bus.in_valid  = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // Single row with the boundary lane values, exact cycle timing.
    for (int i = 0; i < SA_LENGTH; i++) row1[i] = lane_t'(r1[i]);
    cur_sel = 2'b01;
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'b01; bus.cfg_rows = ROW_W'(1); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = row1;
    @(negedge clk);
    check("s1_in_ready", bus.in_ready, 1);
    check("s1_act_in",   bus.act_in,   row1);
    check("s1_act_sel",  bus.act_sel,  2'b01);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < ACT_LATENCY; c++) begin
      @(negedge clk);
      check("s1_out_early", bus.out_valid, 0);
      check("s1_act_sel_hold", bus.act_sel, 2'b01);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("s1_out_valid", bus.out_valid, 1);
    check("s1_out_data",  bus.out_data,  act_fn(row1, 2'b01));
    @(posedge clk); #1;
    @(negedge clk);
    check("s1_done",      bus.done,      1);
    check("s1_cfg_ready", bus.cfg_ready, 0);
    check("s1_sel_done",  bus.act_sel,   2'b01);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("s1_done_low",  bus.done,      0);
    check("s1_idle",      bus.cfg_ready, 1);
    check("s1_busy",      bus.busy,      0);
    check("s1_done_cnt",  done_cnt - d0, 1);

    for (int k = 0; k < 6; k++) begin
      run_layer(vecs[k], n_out, n_done, n_cyc, n_hold);
      check($sformatf("v%0d_outputs", k),  n_out,         vecs[k].rows);
      check($sformatf("v%0d_done", k),     n_done,        1);
      check($sformatf("v%0d_sb_empty", k), exp_q.size(),  0);
      if (vecs[k].exp_cyc > 0)       check($sformatf("v%0d_cycles", k),    n_cyc,  vecs[k].exp_cyc);
      if (vecs[k].exp_hold_iss >= 0) check($sformatf("v%0d_hold_iss", k),  n_hold, vecs[k].exp_hold_iss);
`ifdef ACT_SCHEDULER_PERF_EN
      if (vecs[k].exp_stall >= 0)    check($sformatf("v%0d_stall", k),     stall_cycles, vecs[k].exp_stall);
`endif
    end

    // Reset in the middle of a layer after three issued rows.
    cur_sel = 2'b10;
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'b10; bus.cfg_rows = ROW_W'(8);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand_row();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);

    v2 = '{2'd3, 2, 100, 100, 0, 2 + ACT_LATENCY + 2, -1, -1};
    run_layer(v2, n_out, n_done, n_cyc, n_hold);
    check("post_rst_outputs",  n_out,        2);
    check("post_rst_done",     n_done,       1);
    check("post_rst_cycles",   n_cyc,        v2.exp_cyc);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
